// File: rtl/double_matrix_normalise_pkg.sv
// Shared types for the matrix normaliser: IEEE-754 double container, divider
// result bundle, and the normaliser FSM state encoding.
package fp_double;
   typedef logic [63:0] double;

   localparam logic [10:0] EXP_MAX = 11'h7FF;
   localparam double       QNAN    = 64'h7FF8_0000_0000_0000;

   typedef struct packed {
      double result;
      logic  overflow;
      logic  underflow;
      logic  nan;
      logic  division_by_zero;
   } div_out_t;

   // +0.0 or -0.0: exponent and mantissa both clear
   function automatic logic is_zero(input double v);
      return v[62:0] == 63'd0;
   endfunction
endpackage

package fsm_matop;
   typedef enum logic [1:0] {
      WAIT_MO,
      ISSUE_MO,
      DRAIN_MO,
      FINISHED_MO
   } state_norm;
endpackage

// File: rtl/double_matrix_normalise_fp_div.sv
// Pipelined double-precision divider, round-to-nearest-even, subnormals
// flushed to zero; result and exception flags emerge CYCLES_D clocks after issue.
module fp_div
   import fp_double::*;
#(
   parameter int CYCLES_D = 6
)
(
   input  logic  clk,
   input  logic  aclr,
   input  logic  clk_en,
   input  double dataa,
   input  double datab,
   output double result,
   output logic  overflow,
   output logic  underflow,
   output logic  nan,
   output logic  division_by_zero
);

   logic               w_sign;
   logic               w_a_nan, w_a_inf, w_a_zero;
   logic               w_b_nan, w_b_inf, w_b_zero;
   logic [52:0]        w_ma, w_mb;
   logic               w_ge;
   logic [53:0]        w_num;
   logic [54:0]        w_rem;
   logic [54:0]        w_q;
   logic               w_sticky, w_rnd;
   logic [53:0]        w_mant;
   logic signed [12:0] w_exp;
   div_out_t           w_out;
   div_out_t           r_pipe [CYCLES_D];

   assign w_sign   = dataa[63] ^ datab[63];
   assign w_a_nan  = (dataa[62:52] == EXP_MAX) && (dataa[51:0] != '0);
   assign w_a_inf  = (dataa[62:52] == EXP_MAX) && (dataa[51:0] == '0);
   assign w_a_zero = (dataa[62:52] == '0);
   assign w_b_nan  = (datab[62:52] == EXP_MAX) && (datab[51:0] != '0);
   assign w_b_inf  = (datab[62:52] == EXP_MAX) && (datab[51:0] == '0);
   assign w_b_zero = (datab[62:52] == '0);

   assign w_ma  = {1'b1, dataa[51:0]};
   assign w_mb  = {1'b1, datab[51:0]};
   assign w_ge  = (w_ma >= w_mb);
   // Pre-scale the dividend into [mb, 2*mb) so the quotient always has its MSB at bit 54
   assign w_num = w_ge ? {1'b0, w_ma} : {w_ma, 1'b0};

   always_comb begin
      w_rem = {1'b0, w_num};
      w_q   = '0;
      for (int i = 54; i >= 0; i--) begin
         if (w_rem >= {2'b00, w_mb}) begin
            w_q[i] = 1'b1;
            w_rem  = w_rem - {2'b00, w_mb};
         end
         w_rem = w_rem << 1;
      end
   end

   // q[54] hidden, q[53:2] fraction, q[1] guard, q[0] plus remainder as sticky
   assign w_sticky = w_q[0] | (w_rem != '0);
   assign w_rnd    = w_q[1] & (w_sticky | w_q[2]);
   assign w_mant   = {1'b0, w_q[54:2]} + {53'd0, w_rnd};
   assign w_exp    = {2'b00, dataa[62:52]} + 13'(w_ge ? 1023 : 1022)
                   + {12'd0, w_mant[53]} - {2'b00, datab[62:52]};

   always_comb begin
      w_out = '0;
      if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
         w_out.result = QNAN;
         w_out.nan    = 1'b1;
      end else if (w_a_inf) begin
         w_out.result = {w_sign, EXP_MAX, 52'd0};
      end else if (w_b_zero) begin
         w_out.result           = {w_sign, EXP_MAX, 52'd0};
         w_out.division_by_zero = 1'b1;
      end else if (w_a_zero || w_b_inf) begin
         w_out.result = {w_sign, 63'd0};
      end else if (w_exp >= 13'sd2047) begin
         w_out.result   = {w_sign, EXP_MAX, 52'd0};
         w_out.overflow = 1'b1;
      end else if (w_exp <= 13'sd0) begin
         w_out.result    = {w_sign, 63'd0};
         w_out.underflow = 1'b1;
      end else begin
         w_out.result = {w_sign, w_exp[10:0], w_mant[51:0]};
      end
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         for (int i = 0; i < CYCLES_D; i++) r_pipe[i] <= '0;
      end else if (clk_en) begin
         r_pipe[0] <= w_out;
         for (int i = 1; i < CYCLES_D; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign result           = r_pipe[CYCLES_D-1].result;
   assign overflow         = r_pipe[CYCLES_D-1].overflow;
   assign underflow        = r_pipe[CYCLES_D-1].underflow;
   assign nan              = r_pipe[CYCLES_D-1].nan;
   assign division_by_zero = r_pipe[CYCLES_D-1].division_by_zero;

endmodule

// File: rtl/double_matrix_normalise.sv
// Divides every element of a latched matrix by its latched norm through one
// shared pipelined divider. Optional macro ZERO_NORM_GUARD_EN short-circuits a zero norm.
module double_matrix_normalise
   import fp_double::*;
   import fsm_matop::*;
#(
   parameter int SIZE_A   = 8,
   parameter int SIZE_B   = 8,
   parameter int CYCLES_D = 6
)
(
   input  logic  clk,
   input  logic  rst,
   input  logic  start,
   input  double mat [SIZE_A][SIZE_B],
   input  double norm,
   output double res [SIZE_A][SIZE_B],
   output logic  f,
   output logic  err
);

   localparam int            RW       = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
   localparam int            CW       = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
   localparam logic [RW-1:0] ROW_LAST = RW'(SIZE_A - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(SIZE_B - 1);

   state_norm       r_state, w_state_nxt;
   double           r_mat [SIZE_A][SIZE_B];
   double           r_res [SIZE_A][SIZE_B];
   double           r_norm;
   logic [RW-1:0]   r_row;
   logic [CW-1:0]   r_col;
   logic [CYCLES_D-1:0] r_vld_sr;
   logic [RW-1:0]   r_row_sr [CYCLES_D];
   logic [CW-1:0]   r_col_sr [CYCLES_D];
   logic            r_f, r_err;

   logic            w_latch, w_issue, w_issue_last;
   logic            w_emerge, w_em_last;
   logic [RW-1:0]   w_em_row;
   logic [CW-1:0]   w_em_col;
   double           w_dataa, w_quot;
   logic            w_ovf, w_unf, w_nan, w_dbz, w_div_flag;

`ifdef ZERO_NORM_GUARD_EN
   logic            r_zpend;
   assign w_latch = (r_state == WAIT_MO) && start && !r_zpend;
`else
   assign w_latch = (r_state == WAIT_MO) && start;
`endif

   assign w_issue      = (r_state == ISSUE_MO);
   assign w_issue_last = w_issue && (r_row == ROW_LAST) && (r_col == COL_LAST);
   assign w_emerge     = r_vld_sr[CYCLES_D-1];
   assign w_em_row     = r_row_sr[CYCLES_D-1];
   assign w_em_col     = r_col_sr[CYCLES_D-1];
   assign w_em_last    = w_emerge && (w_em_row == ROW_LAST) && (w_em_col == COL_LAST);
   assign w_dataa      = r_mat[r_row][r_col];
   assign w_div_flag   = w_ovf | w_unf | w_nan | w_dbz;

   fp_div #(.CYCLES_D(CYCLES_D)) u_fp_div (
      .clk              (clk),
      .aclr             (rst),
      .clk_en           (1'b1),
      .dataa            (w_dataa),
      .datab            (r_norm),
      .result           (w_quot),
      .overflow         (w_ovf),
      .underflow        (w_unf),
      .nan              (w_nan),
      .division_by_zero (w_dbz)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         WAIT_MO: begin
`ifdef ZERO_NORM_GUARD_EN
            // A zero norm latches, waits one cycle in WAIT_MO, then jumps straight to done
            if (r_zpend)
               w_state_nxt = FINISHED_MO;
            else if (start && !is_zero(norm))
               w_state_nxt = ISSUE_MO;
`else
            if (start)
               w_state_nxt = ISSUE_MO;
`endif
         end
         ISSUE_MO:    if (w_issue_last) w_state_nxt = DRAIN_MO;
         DRAIN_MO:    if (w_em_last)    w_state_nxt = FINISHED_MO;
         FINISHED_MO: if (!start)       w_state_nxt = WAIT_MO;
         default:                       w_state_nxt = WAIT_MO;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= WAIT_MO;
         r_f      <= 1'b0;
         r_err    <= 1'b0;
         r_norm   <= '0;
         r_row    <= '0;
         r_col    <= '0;
         r_vld_sr <= '0;
         for (int i = 0; i < CYCLES_D; i++) begin
            r_row_sr[i] <= '0;
            r_col_sr[i] <= '0;
         end
`ifdef ZERO_NORM_GUARD_EN
         r_zpend  <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         // Done rises one clock into FINISHED_MO and falls with the exit edge
         r_f         <= (r_state == FINISHED_MO) && start;
         r_vld_sr[0] <= w_issue;
         r_row_sr[0] <= r_row;
         r_col_sr[0] <= r_col;
         for (int i = 1; i < CYCLES_D; i++) begin
            r_vld_sr[i] <= r_vld_sr[i-1];
            r_row_sr[i] <= r_row_sr[i-1];
            r_col_sr[i] <= r_col_sr[i-1];
         end
         if (w_latch) begin
            r_norm <= norm;
            r_err  <= 1'b0;
            r_row  <= '0;
            r_col  <= '0;
`ifdef ZERO_NORM_GUARD_EN
            r_zpend <= is_zero(norm);
`endif
         end else if (w_issue) begin
            if (r_col == COL_LAST) begin
               r_col <= '0;
               r_row <= r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
`ifdef ZERO_NORM_GUARD_EN
         if (r_zpend) begin
            r_zpend <= 1'b0;
            r_err   <= 1'b1;
         end
`endif
         if (w_emerge && w_div_flag) r_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SIZE_A; i++)
            for (int j = 0; j < SIZE_B; j++)
               r_res[i][j] <= '0;
      end else begin
`ifdef ZERO_NORM_GUARD_EN
         if (r_zpend) begin
            for (int i = 0; i < SIZE_A; i++)
               for (int j = 0; j < SIZE_B; j++)
                  r_res[i][j] <= '0;
         end
`endif
         if (w_emerge) r_res[w_em_row][w_em_col] <= w_quot;
      end
   end

   always_ff @(posedge clk) begin
      if (w_latch) r_mat <= mat;
   end

   assign res = r_res;
   assign f   = r_f;
   assign err = r_err;

endmodule

// File: doc/double_matrix_normalise.md
DOUBLE_MATRIX_NORMALISE -- requirements
Module: double_matrix_normalise

Interface
REQ-001 SHALL have parameter SIZE_A, default 8, meaning matrix rows.
REQ-002 SHALL have parameter SIZE_B, default 8, meaning matrix columns.
REQ-003 SHALL have parameter CYCLES_D, default 6, meaning fp_div pipeline latency in clocks.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port start, input, 1, run request (driven by upstream norm-done flag f).
REQ-007 SHALL have port mat, input, double[SIZE_A][SIZE_B], matrix to normalise.
REQ-008 SHALL have port norm, input, double, Frobenius norm of mat.
REQ-009 SHALL have port res, output, double[SIZE_A][SIZE_B], the matrix mat/norm, registered.
REQ-010 SHALL have port f, output, 1, done flag.
REQ-011 SHALL have port err, output, 1, sticky arithmetic exception flag.

Function
REQ-012 SHALL implement FSM states WAIT_MO, ISSUE_MO, DRAIN_MO, FINISHED_MO.
REQ-013 SHALL, in WAIT_MO with start=1, latch norm and all of mat into internal registers, clear err, zero issue index, and enter ISSUE_MO.
REQ-014 SHALL, in ISSUE_MO, present one latched element per cycle to fp_div (dataa=element, datab=latched norm), row-major, index 0..N-1 where N=SIZE_A*SIZE_B.
REQ-015 SHALL enter DRAIN_MO after issuing index N-1.
REQ-016 SHALL carry each issued index through a CYCLES_D-deep valid/index shift register and write the fp_div result to res[idx/SIZE_B][idx%SIZE_B] when it emerges.
REQ-017 SHALL leave DRAIN_MO for FINISHED_MO in the cycle the last result (index N-1) is written.
REQ-018 SHALL give latency: start sampled at edge 0 -> f=1 after edge N+CYCLES_D+1 (71 for defaults).
REQ-019 SHALL hold f=1 only in FINISHED_MO, and return to WAIT_MO when start=0; f drops on the same edge.
REQ-020 SHALL stay in FINISHED_MO while start remains 1, and SHALL NOT start a new run until start has been seen low.
REQ-021 SHALL ignore start outside WAIT_MO and SHALL ignore changes on mat/norm after latching.
REQ-022 SHALL set err if any fp_div overflow, underflow, nan or division_by_zero flag is high for a valid result; err stays high until the next run starts.
REQ-023 SHALL leave res unchanged between runs; res elements not yet rewritten keep prior-run values until overwritten.

Reset
REQ-024 SHALL, on rst=1 at any time including mid-run, force state to WAIT_MO, f=0, err=0, all res=+0.0, index=0, and clear all valid-pipeline bits.
REQ-025 SHALL keep fp_div aclr tied to rst, and SHALL NOT write any result still in flight at reset.

Configuration
REQ-026 SHALL support macro ZERO_NORM_GUARD_EN.
REQ-027 SHALL, when ZERO_NORM_GUARD_EN is defined and the latched norm is +/-0.0 (exponent and mantissa zero), skip division, set all res=+0.0 and err=1, go WAIT_MO->FINISHED_MO directly, with f=1 after edge 2.
REQ-028 SHALL, when ZERO_NORM_GUARD_EN is undefined, divide normally and report err from fp_div flags only.

Structure
REQ-029 SHALL use type double from package fp_double.
REQ-030 SHALL place the state enum state_norm (WAIT_MO, ISSUE_MO, DRAIN_MO, FINISHED_MO) in package fsm_matop.
REQ-031 SHALL instantiate exactly one sub-module, fp_div (double-precision divider IP, latency CYCLES_D, clk_en tied 1).

Verification
REQ-032 SHALL test: mat all 2.0, norm 16.0, start=1 -> all res=0.125, err=0, f rises after edge 71.
REQ-033 SHALL test: mat[i][j]=i*8+j, norm 4.0 -> res[0][1]=0.25, res[7][7]=15.75, res[3][2]=6.5.
REQ-034 SHALL test: norm 0.0, mat all 1.0 -> with ZERO_NORM_GUARD_EN res all 0.0, err=1, f after edge 2; without it res +inf, err=1, f after edge 71.
REQ-035 SHALL test: rst pulsed at edge 20 of a run -> f=0, err=0, res all 0.0, state WAIT_MO; a fresh start then completes correctly.
REQ-036 SHALL test: after f=1, deassert start -> f=0 next edge; restart with norm 2.0, mat all 3.0 -> all res=1.5.
